// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: reset/bubble constants, fetch FSM states,
// fetch queue entry layout and the branch/jump redirect-priority rule.
package pipeline_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] RESET_PC  = 32'h0000_0000;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0000;

  typedef enum logic [0:0] {
    FETCH = 1'b0,
    DROP  = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0] pc_plus4;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

  // Entry presented when the queue is empty: IF/ID latches a bubble.
  localparam fetch_entry_t EMPTY_ENTRY = '{pc_plus4: 32'h0, instr: NOP_INSTR};

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] target;
  } redirect_t;

  // Jump wins over a taken branch; targets are forced word-aligned.
  function automatic redirect_t redirect_sel(input logic            jump,
                                             input logic            branch_taken,
                                             input logic [XLEN-1:0] jump_target,
                                             input logic [XLEN-1:0] branch_target);
    redirect_t       r;
    logic [XLEN-1:0] sel;
    sel      = jump ? jump_target : branch_target;
    r.valid  = jump | branch_taken;
    r.target = {sel[XLEN-1:2], 2'b00};
    return r;
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Two-entry FIFO of fetched {PC+4, instruction} pairs.
// Ports: push/push_data enqueue, pop dequeues the head, flush empties
// (flush beats push and pop), count = occupancy, head = head entry flops
// (EMPTY_ENTRY when count is 0).
module fetch_queue
  import pipeline_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  fetch_entry_t push_data,
  input  logic         pop,
  input  logic         flush,
  output logic [1:0]   count,
  output fetch_entry_t head
);

  logic [1:0]   count_q, count_d;
  fetch_entry_t head_q, head_d;
  fetch_entry_t tail_q, tail_d;
  logic         do_pop;
  logic         do_push;

  // Occupancy and head/tail shifting.
  always_comb begin
    count_d = count_q;
    head_d  = head_q;
    tail_d  = tail_q;
    do_pop  = pop && (count_q != 2'd0);
    do_push = push && ((count_q != 2'd2) || do_pop);
    if (flush) begin
      count_d = 2'd0;
      head_d  = EMPTY_ENTRY;
    end else if (do_pop && do_push) begin
      if (count_q == 2'd1) begin
        head_d = push_data;
      end else begin
        head_d = tail_q;
        tail_d = push_data;
      end
    end else if (do_pop) begin
      head_d  = (count_q == 2'd2) ? tail_q : EMPTY_ENTRY;
      count_d = count_q - 2'd1;
    end else if (do_push) begin
      if (count_q == 2'd0) begin
        head_d = push_data;
      end else begin
        tail_d = push_data;
      end
      count_d = count_q + 2'd1;
    end
  end

  // Queue state flops.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= 2'd0;
      head_q  <= EMPTY_ENTRY;
      tail_q  <= EMPTY_ENTRY;
    end else begin
      count_q <= count_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
    end
  end

  assign count = count_q;
  assign head  = head_q;

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, fetches words over a req/ack
// handshake, buffers up to two instructions for IF/ID.
// Ports: PC_Write (consume head), branch_taken/branch_target and
// jump/jump_target (ID redirects), imem_req/imem_addr/imem_ack/imem_rdata
// (instruction memory), PC_plus4_out/instruction_out/fetch_valid (head entry).
module if_fetch_unit
  import pipeline_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        PC_Write,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] PC_plus4_out,
  output logic [31:0] instruction_out,
  output logic        fetch_valid
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  hold_addr_q, hold_addr_d;

  redirect_t    redir;
  logic [31:0]  pc_plus4;
  logic         q_push;
  logic         q_pop;
  logic         q_flush;
  logic [1:0]   q_count;
  fetch_entry_t q_head;

  fetch_queue u_queue (
    .clk       (clk),
    .reset     (reset),
    .push      (q_push),
    .push_data ('{pc_plus4: pc_plus4, instr: imem_rdata}),
    .pop       (q_pop),
    .flush     (q_flush),
    .count     (q_count),
    .head      (q_head)
  );

  assign redir    = redirect_sel(jump, branch_taken, jump_target, branch_target);
  assign pc_plus4 = pc_q + 32'd4;

  // Request side. In DROP the abandoned address stays on the bus until its ack,
  // while pc already holds the redirect target.
  always_comb begin
    imem_req  = !reset && ((state_q == DROP) || (q_count != 2'd2));
    imem_addr = (state_q == DROP) ? hold_addr_q : pc_q;
  end

  // Next-state, PC and queue control.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    hold_addr_d = hold_addr_q;
    q_push      = 1'b0;
    q_pop       = 1'b0;
    q_flush     = 1'b0;
    if (redir.valid) begin
      q_flush = 1'b1;
      pc_d    = redir.target;
      if (state_q == FETCH) begin
        if (imem_req && !imem_ack) begin
          state_d     = DROP;
          hold_addr_d = pc_q;
        end
      end else if (imem_ack) begin
        // Outstanding wrong-path request completes now; fetch the new target.
        state_d = FETCH;
      end
    end else if (state_q == FETCH) begin
      if (imem_req && imem_ack) begin
        q_push = 1'b1;
        pc_d   = pc_plus4;
      end
      q_pop = fetch_valid && PC_Write;
    end else if (imem_ack) begin
      state_d = FETCH;
    end
  end

  // State flops.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= FETCH;
      pc_q        <= RESET_PC;
      hold_addr_q <= RESET_PC;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      hold_addr_q <= hold_addr_d;
    end
  end

  assign fetch_valid     = (q_count != 2'd0);
  assign PC_plus4_out    = q_head.pc_plus4;
  assign instruction_out = q_head.instr;

endmodule

// File: tb/tb_if_fetch_unit.sv
module tb_if_fetch_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        PC_Write = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = 32'h0;
  logic        jump = 1'b0;
  logic [31:0] jump_target = 32'h0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] PC_plus4_out;
  logic [31:0] instruction_out;
  logic        fetch_valid;

  int n_cmp = 0;
  int n_err = 0;
  int lat = 0;
  int wait_cnt = 0;

  if_fetch_unit dut (
    .clk             (clk),
    .reset           (reset),
    .PC_Write        (PC_Write),
    .branch_taken    (branch_taken),
    .branch_target   (branch_target),
    .jump            (jump),
    .jump_target     (jump_target),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_ack        (imem_ack),
    .imem_rdata      (imem_rdata),
    .PC_plus4_out    (PC_plus4_out),
    .instruction_out (instruction_out),
    .fetch_valid     (fetch_valid)
  );

  always #5 clk = ~clk;

  // Memory model: data = addr + 0x100, ack after 'lat' extra request cycles.
  assign imem_rdata = imem_addr + 32'h100;
  assign imem_ack   = imem_req && (wait_cnt >= lat);

  always @(posedge clk or posedge reset) begin
    if (reset)                      wait_cnt <= 0;
    else if (imem_req && imem_ack)  wait_cnt <= 0;
    else if (imem_req)              wait_cnt <= wait_cnt + 1;
  end

  typedef struct {
    logic        rst;
    logic        pcw;
    logic        br;
    logic [31:0] br_t;
    logic        jmp;
    logic [31:0] jmp_t;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_pc4;
    logic [31:0] e_instr;
  } vec_t;

  localparam int NV = 16;
  vec_t vecs [NV];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    PC_Write = 1'b0; branch_taken = 1'b0; jump = 1'b0;
    #1;
    chk("rst_req",   32'(imem_req), 32'h0);
    chk("rst_valid", 32'(fetch_valid), 32'h0);
    chk("rst_instr", instruction_out, 32'h0);
    chk("rst_pc4",   PC_plus4_out, 32'h0);
    step();
    reset = 1'b0;
  endtask

  initial begin
    // rst pcw br br_t jmp jmp_t | req addr valid pc4 instr
    vecs[0]  = '{1'b1, 1'b1, 1'b0, 32'h0,  1'b0, 32'h0,        1'b1, 32'h0,        1'b0, 32'h0,  32'h0};
    vecs[1]  = '{1'b0, 1'b1, 1'b0, 32'h0,  1'b0, 32'h0,        1'b1, 32'h4,        1'b1, 32'h4,  32'h100};
    vecs[2]  = '{1'b0, 1'b1, 1'b0, 32'h0,  1'b0, 32'h0,        1'b1, 32'h8,        1'b1, 32'h8,  32'h104};
    vecs[3]  = '{1'b0, 1'b1, 1'b0, 32'h0,  1'b0, 32'h0,        1'b1, 32'hC,        1'b1, 32'hC,  32'h108};
    vecs[4]  = '{1'b1, 1'b0, 1'b0, 32'h0,  1'b0, 32'h0,        1'b1, 32'h0,        1'b0, 32'h0,  32'h0};
    vecs[5]  = '{1'b0, 1'b0, 1'b0, 32'h0,  1'b0, 32'h0,        1'b1, 32'h4,        1'b1, 32'h4,  32'h100};
    vecs[6]  = '{1'b0, 1'b0, 1'b0, 32'h0,  1'b0, 32'h0,        1'b0, 32'h8,        1'b1, 32'h4,  32'h100};
    vecs[7]  = '{1'b0, 1'b1, 1'b0, 32'h0,  1'b0, 32'h0,        1'b0, 32'h8,        1'b1, 32'h4,  32'h100};
    vecs[8]  = '{1'b0, 1'b1, 1'b0, 32'h0,  1'b0, 32'h0,        1'b1, 32'h8,        1'b1, 32'h8,  32'h104};
    vecs[9]  = '{1'b0, 1'b1, 1'b0, 32'h0,  1'b0, 32'h0,        1'b1, 32'hC,        1'b1, 32'hC,  32'h108};
    vecs[10] = '{1'b0, 1'b1, 1'b0, 32'h0,  1'b1, 32'hFFFF_FFFF, 1'b1, 32'h10,       1'b1, 32'h10, 32'h10C};
    vecs[11] = '{1'b0, 1'b1, 1'b0, 32'h0,  1'b0, 32'h0,        1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0,  32'h0};
    vecs[12] = '{1'b0, 1'b1, 1'b0, 32'h0,  1'b0, 32'h0,        1'b1, 32'h0,        1'b1, 32'h0,  32'hFC};
    vecs[13] = '{1'b0, 1'b1, 1'b1, 32'h40, 1'b1, 32'h80,       1'b1, 32'h4,        1'b1, 32'h4,  32'h100};
    vecs[14] = '{1'b0, 1'b1, 1'b0, 32'h0,  1'b0, 32'h0,        1'b1, 32'h80,       1'b0, 32'h0,  32'h0};
    vecs[15] = '{1'b0, 1'b1, 1'b0, 32'h0,  1'b0, 32'h0,        1'b1, 32'h84,       1'b1, 32'h84, 32'h180};

    // Zero-wait table: streaming, back-pressure, wrap, redirect priority.
    lat = 0;
    for (int i = 0; i < NV; i++) begin
      if (vecs[i].rst) do_reset();
      PC_Write      = vecs[i].pcw;
      branch_taken  = vecs[i].br;
      branch_target = vecs[i].br_t;
      jump          = vecs[i].jmp;
      jump_target   = vecs[i].jmp_t;
      #1;
      chk($sformatf("v%0d_req", i),   32'(imem_req),    32'(vecs[i].e_req));
      chk($sformatf("v%0d_addr", i),  imem_addr,        vecs[i].e_addr);
      chk($sformatf("v%0d_valid", i), 32'(fetch_valid), 32'(vecs[i].e_valid));
      chk($sformatf("v%0d_pc4", i),   PC_plus4_out,     vecs[i].e_pc4);
      chk($sformatf("v%0d_instr", i), instruction_out,  vecs[i].e_instr);
      step();
    end
    branch_taken = 1'b0; jump = 1'b0;

    // Slow memory with a branch during the wait: old request drained and discarded.
    lat = 2;
    do_reset();
    #1;
    chk("slow_c0_req",  32'(imem_req), 32'h1);
    chk("slow_c0_ack",  32'(imem_ack), 32'h0);
    step();
    branch_taken = 1'b1; branch_target = 32'h40;
    #1;
    chk("slow_c1_addr", imem_addr, 32'h0);
    step();
    branch_taken = 1'b0;
    #1;
    chk("slow_drop_req",  32'(imem_req), 32'h1);
    chk("slow_drop_addr", imem_addr, 32'h0);
    chk("slow_drop_ack",  32'(imem_ack), 32'h1);
    step();
    chk("slow_tgt_addr",  imem_addr, 32'h40);
    chk("slow_tgt_valid", 32'(fetch_valid), 32'h0);
    begin
      int k;
      k = 0;
      while (!fetch_valid && k < 10) begin
        step();
        k++;
      end
      chk("slow_wait_cycles", 32'(k), 32'd3);
    end
    chk("slow_out_pc4",   PC_plus4_out, 32'h44);
    chk("slow_out_instr", instruction_out, 32'h140);

    // Asynchronous reset mid-wait with one entry queued.
    lat = 0;
    do_reset();
    step();
    lat = 2;
    #1;
    chk("ar_pre_valid", 32'(fetch_valid), 32'h1);
    chk("ar_pre_addr",  imem_addr, 32'h4);
    chk("ar_pre_ack",   32'(imem_ack), 32'h0);
    #2;
    reset = 1'b1;
    #1;
    chk("ar_valid", 32'(fetch_valid), 32'h0);
    chk("ar_instr", instruction_out, 32'h0);
    chk("ar_pc4",   PC_plus4_out, 32'h0);
    chk("ar_req",   32'(imem_req), 32'h0);
    step();
    reset = 1'b0;
    lat = 0;
    #1;
    chk("ar_post_req",  32'(imem_req), 32'h1);
    chk("ar_post_addr", imem_addr, 32'h0);
    step();
    chk("ar_post_pc4",   PC_plus4_out, 32'h4);
    chk("ar_post_instr", instruction_out, 32'h100);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
